// File: rtl/serial_frame_pkg.sv
// Shared encodings for the serial frame transmitter: FSM states and line levels.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_frame_tx_bit_period_cnt.sv
// Bit-period timer: tick marks the last clock of each CLKS_PER_BIT-long bit.
module bit_period_cnt #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // With one clock per bit LAST is 0, so the counter never leaves 0.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, data MSB first, optional
// parity, stop bit; each bit held for CLKS_PER_BIT clocks, line idles high.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sdo,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt, shifted;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic              par, par_nxt;
    logic              sdo_nxt;
    logic              clear;
    logic              tick;

    bit_period_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_period (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .tick    (tick)
    );

    assign tx_ready   = (state == IDLE);
    assign busy       = !tx_ready;
    assign frame_done = (state == STOP) && tick;
    assign shifted    = shreg << 1;

    // sdo is registered one bit ahead: each transition loads the level of the
    // bit that starts on that edge.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par;
        sdo_nxt     = sdo;
        clear       = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt   = START;
                    sdo_nxt     = START_BIT;
                    shreg_nxt   = tx_data;
                    bit_cnt_nxt = '0;
                    par_nxt     = (^tx_data) ^ (PARITY_ODD != 0);
                    clear       = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    sdo_nxt   = shreg[DATA_W-1];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            sdo_nxt   = par;
                        end else begin
                            state_nxt = STOP;
                            sdo_nxt   = LINE_IDLE;
                        end
                    end else begin
                        shreg_nxt   = shifted;
                        sdo_nxt     = shifted[DATA_W-1];
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    sdo_nxt   = LINE_IDLE;
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    sdo_nxt   = LINE_IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                sdo_nxt   = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            sdo     <= LINE_IDLE;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            par     <= par_nxt;
            sdo     <= sdo_nxt;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx across four parameterisations, plus a
// 4-bit shift register chained on the default instance's sdo.
module tb_serial_frame_tx;

    typedef logic [1:0] exp_t;  // {sdo, frame_done} for one clock

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] d [4];
    logic [3:0] v;
    wire  [3:0] rdy, bsy, sdo, done;
    logic [3:0] siso;

    int tests = 0;
    int fails = 0;

    exp_t q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;

    // 0: defaults  1: odd parity  2: no parity  3: 4 clocks per bit
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u_def (
        .clk(clk), .reset_n(reset_n), .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
        .sdo(sdo[0]), .busy(bsy[0]), .frame_done(done[0]));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .reset_n(reset_n), .tx_data(d[1]), .tx_valid(v[1]), .tx_ready(rdy[1]),
        .sdo(sdo[1]), .busy(bsy[1]), .frame_done(done[1]));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
        .clk(clk), .reset_n(reset_n), .tx_data(d[2]), .tx_valid(v[2]), .tx_ready(rdy[2]),
        .sdo(sdo[2]), .busy(bsy[2]), .frame_done(done[2]));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_c4 (
        .clk(clk), .reset_n(reset_n), .tx_data(d[3]), .tx_valid(v[3]), .tx_ready(rdy[3]),
        .sdo(sdo[3]), .busy(bsy[3]), .frame_done(done[3]));

    // Downstream 4-bit SISO sharing clock and reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) siso <= 4'd0;
        else          siso <= {siso[2:0], sdo[0]};
    end

    task automatic chk1(input string name, input int id, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d @%0t: got %b expected %b", name, id, $time, act, exp);
        end
    endtask

    task automatic chk16(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, id, $time, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input exp_t e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int id, output exp_t e, output bit ok);
        e = '0;
        ok = 1'b0;
        case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    // Monitor: every busy clock consumes one expected {sdo, frame_done}.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ok;
        if (reset_n) begin
            for (int i = 0; i < 4; i++) begin
                if (bsy[i]) begin
                    pop_exp(i, e, ok);
                    chk1("scoreboard_underflow", i, ok, 1'b1);
                    if (ok) begin
                        chk1("sdo", i, sdo[i], e[1]);
                        chk1("frame_done", i, done[i], e[0]);
                    end
                end else begin
                    chk1("idle_sdo", i, sdo[i], 1'b1);
                    chk1("idle_done", i, done[i], 1'b0);
                end
                chk1("busy_vs_ready", i, bsy[i], !rdy[i]);
            end
        end
    end

    // Present a word from posedge+1; bits holds the hand-computed frame with
    // the first-transmitted bit at position nbits-1.
    task automatic send(input int id, input logic [7:0] w, input logic [15:0] bits,
                        input int nbits, input bit hold, output time t_acc);
        bit ok = 1'b0;
        bit r;
        int c = (id == 3) ? 4 : 1;
        t_acc = 0;
        d[id] = w;
        v[id] = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            r = rdy[id];
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                t_acc = $time;
                for (int n = nbits - 1; n >= 0; n--)
                    for (int k = 0; k < c; k++)
                        push_exp(id, {bits[n], (n == 0 && k == c - 1)});
            end
            #1;
        end
        if (!hold) v[id] = 1'b0;
        chk1("accept_timeout", id, ok, 1'b1);
    endtask

    task automatic drain(input int id);
        for (int t = 0; t < 100 && qsize(id) != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk16("scoreboard_leftover", id, 16'(qsize(id)), 16'd0);
    endtask

    initial begin : stim
        time ta, tb;
        logic [15:0] a5;
        logic        eb;
        a5 = 16'b00000_0_10100101_0_1;
        v = '0;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;

        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk16("reset_ready", 0, {12'd0, rdy}, 16'h000F);
        chk16("reset_busy", 0, {12'd0, bsy}, 16'h0000);
        chk16("reset_sdo", 0, {12'd0, sdo}, 16'h000F);
        chk16("reset_done", 0, {12'd0, done}, 16'h0000);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Defaults, 0xA5, even parity 0
        send(0, 8'hA5, a5, 11, 1'b0, ta);
        drain(0);

        // Odd parity on zero word; no-parity 10-bit frame
        send(1, 8'h00, 16'b00000_0_00000000_1_1, 11, 1'b0, ta);
        send(2, 8'hFF, 16'b000000_0_11111111_1, 10, 1'b0, ta);
        drain(1);
        drain(2);

        // Four clocks per bit, 0x80 -> parity 1, 44 clocks
        send(3, 8'h80, 16'b00000_0_10000000_1_1, 11, 1'b0, ta);
        drain(3);

        // Back-to-back with valid held; data changes while frames are in flight
        send(0, 8'h3C, 16'b00000_0_00111100_0_1, 11, 1'b1, ta);
        send(0, 8'hC3, 16'b00000_0_11000011_0_1, 11, 1'b0, tb);
        d[0] = 8'hFF;
        chk16("b2b_gap_clocks", 0, 16'((tb - ta) / 10), 16'd12);
        drain(0);

        // Reset in clock 5 of a frame
        send(0, 8'hA5, a5, 11, 1'b0, ta);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        q0.delete();
        #1;
        chk1("midreset_sdo", 0, sdo[0], 1'b1);
        chk1("midreset_ready", 0, rdy[0], 1'b1);
        chk1("midreset_busy", 0, bsy[0], 1'b0);
        chk1("midreset_done", 0, done[0], 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(0, 8'h5A, 16'b00000_0_01011010_0_1, 11, 1'b0, ta);
        drain(0);

        // Chained SISO: its output is the frame delayed by four clocks
        repeat (5) @(posedge clk);
        #1;
        send(0, 8'hA5, a5, 11, 1'b0, ta);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            eb = (i < 4) ? 1'b1 : a5[14 - i];
            chk1("siso_out", 0, siso[3], eb);
        end
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter; sits directly upstream of the 4-bit SISO shift register, driving its serial input.
- Accepts a DATA_W-bit word on a valid/ready handshake and emits one serial frame: start bit, data MSB first, optional parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clocks. The line idles high.

Parameters:
- DATA_W, 8, payload width in bits; must be >= 1.
- CLKS_PER_BIT, 1, clocks per serial bit; must be >= 1.
- PARITY_EN, 1, 1 = parity bit inserted after the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- tx_data  input  DATA_W  word to send; sampled only on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word.
- sdo  output  1  serial data out, registered; connects to the SISO sdi.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse in the final clock of the stop bit.

Behaviour:
- Reset values: sdo=1, tx_ready=1, busy=0, frame_done=0; state IDLE; shift register, bit counter and period counter all 0.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously), and the frame in progress is discarded.
- Handshake:
  - Acceptance occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready = (state==IDLE); it is a pure state decode with no combinational path from tx_valid.
  - The word is latched into an internal shift register at acceptance. Later changes to tx_data are ignored.
  - tx_valid while busy has no effect; the word waits.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE -> START on acceptance; sdo<=0 on the same edge.
  - START -> DATA after CLKS_PER_BIT clocks.
  - DATA: sdo carries shreg[DATA_W-1]. Shift left every CLKS_PER_BIT clocks, DATA_W bits total.
  - DATA -> PARITY if PARITY_EN, otherwise DATA -> STOP.
  - PARITY: sdo = (^word) XOR PARITY_ODD, for CLKS_PER_BIT clocks, then -> STOP.
  - STOP: sdo=1 for CLKS_PER_BIT clocks, then -> IDLE.
- Timing:
  - Let acceptance be edge k. Bit n of the frame (n=0 is start) appears on sdo from edge k+n*CLKS_PER_BIT until edge k+(n+1)*CLKS_PER_BIT.
  - Frame length is F = (2+DATA_W+PARITY_EN) bits.
  - frame_done is high during the clock cycle that precedes edge k+F*CLKS_PER_BIT.
  - At edge k+F*CLKS_PER_BIT, state goes to IDLE and tx_ready rises.
  - Next possible acceptance is edge k+F*CLKS_PER_BIT+1, so back-to-back frames always have exactly 1 idle-high clock between them.
- busy = !tx_ready.
- Counters:
  - The period counter is sized $clog2(CLKS_PER_BIT+1) and wraps from CLKS_PER_BIT-1 to 0.
  - The bit counter is sized $clog2(DATA_W+1).
  - With CLKS_PER_BIT=1 the period counter is constant 0 and every clock is a bit boundary.
- sdo is always a flop output; it is never glitch-combinational.

Decomposition:
- Package serial_frame_pkg:
  - state encoding constants: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - line-level constants LINE_IDLE=1'b1 and START_BIT=1'b0.
- Sub-module bit_period_cnt(clk, reset_n, clear, tick), parameter CLKS_PER_BIT.
  - tick pulses on the last clock of each bit period.
  - clear restarts the count; it is asserted at acceptance.

Test Plan:
1. Defaults (DATA_W=8, CLKS_PER_BIT=1, even parity): send 0xA5 -> sdo sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 clocks. tx_ready low for 11 clocks, frame_done high in the 11th, sdo=1 afterwards.
2. PARITY_ODD=1: send 0x00 -> parity bit 1, giving sdo 0,0,0,0,0,0,0,0,0,1,1. With PARITY_EN=0: send 0xFF -> 0,1,1,1,1,1,1,1,1,1, a 10-bit frame.
3. CLKS_PER_BIT=4: send 0x80 -> start low for 4 clocks, sdo high for 4, low for 28, parity 1 for 4, stop 1 for 4. Total 44 clocks; frame_done high in clock 44 only.
4. tx_valid held high with 0x3C then 0xC3 queued: second acceptance exactly 12 clocks after the first (1 idle clock). tx_data changed mid-frame to 0xFF -> transmitted bits unchanged.
5. Reset pulse at clock 5 of a frame -> sdo=1 and tx_ready=1 asynchronously. After release, a fresh 0x5A frame is transmitted correctly.
6. Chained with the 4-bit SISO (sdo -> sdi, shared clk/reset_n): SISO sdo equals this block's sdo delayed by exactly 4 clocks for the 0xA5 frame.
